// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants, state encoding and ring arithmetic for the memory arbiter
package mem_arb_pkg;
  localparam int N_PORTS = 5;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] RR_RESET = '0;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] p, input int unsigned k);
    return SEL_W'((32'(p) + k) % N_PORTS);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping past the last port
module rr_pick import mem_arb_pkg::*; (
  input  logic [N_PORTS-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);
  // scan from the farthest offset down so the nearest requester wins
  always_comb begin
    valid = |req;
    idx = ptr;
    for (int i = N_PORTS - 1; i >= 0; i--) idx = req[wrap_add(ptr, i)] ? wrap_add(ptr, i) : idx;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: five-port round-robin memory arbiter with hold-time preemption and burst lock
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int MAX_HOLD = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_PORTS-1:0] req_i,
  input  logic [N_PORTS-1:0] lock_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               we_en_o,
  output logic               busy_o
);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  state_t state;
  logic [CW-1:0] cnt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic pick_v;
  logic at_max;
  logic leave;
  rr_pick u_pick (.req(req_i), .ptr(rr_ptr), .valid(pick_v), .idx(pick_idx));
  assign at_max = cnt == HOLD_MAX;
  assign leave = ~|(req_i & gnt_o) |
                 ((MAX_HOLD != 0) & at_max & (|(req_i & ~gnt_o)) & ~|(lock_i & gnt_o));
  assign we_en_o = state == GRANT;
  assign busy_o = state != IDLE;
  // owner holds until release or preemption; IDLE and TURN both arbitrate on current requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_o <= '0;
      sel_o <= '0;
      rr_ptr <= RR_RESET;
      cnt <= '0;
    end else if (state == GRANT) begin
      if (leave) begin
        state <= TURN;
        gnt_o <= '0;
      end else if (!at_max) cnt <= cnt + 1'b1;
    end else if (pick_v) begin
      state <= GRANT;
      gnt_o <= N_PORTS'(1) << pick_idx;
      sel_o <= pick_idx;
      rr_ptr <= wrap_add(pick_idx, 1);
      cnt <= '0;
    end else state <= IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench comparing the arbiter against an owner-based reference model
module tb_mem_arbiter;
  localparam int MH = 4;
  localparam int STARVE = 4 * (MH + 2);
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [4:0] req_i = 5'd0;
  logic [4:0] lock_i = 5'd0;
  logic [4:0] gnt_o;
  logic [2:0] sel_o;
  logic we_en_o;
  logic busy_o;
  typedef struct {
    logic [4:0] gnt;
    int sel;
    logic we;
    logic busy;
    logic rst;
    logic [4:0] req;
    logic starve_en;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int owner = -1;
  int last_sel = 0;
  int ptr = 0;
  int held = 0;
  bit turn = 1'b0;
  logic starve_en = 1'b0;

  mem_arbiter #(.MAX_HOLD(MH)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i),
    .gnt_o(gnt_o), .sel_o(sel_o), .we_en_o(we_en_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic model(input logic r, input logic [4:0] rq, input logic [4:0] lk);
    if (r) begin
      owner = -1; turn = 1'b0; last_sel = 0; ptr = 0; held = 0;
    end else if (owner >= 0) begin
      bit contended;
      contended = |(rq & ~(5'b1 << owner));
      if (!rq[owner] || (MH != 0 && held == MH && contended && !lk[owner])) begin
        owner = -1; turn = 1'b1;
      end else if (held < MH) held++;
    end else begin
      turn = 1'b0;
      for (int i = 0; i < 5; i++) if (owner < 0 && rq[(ptr + i) % 5]) owner = (ptr + i) % 5;
      if (owner >= 0) begin
        last_sel = owner; ptr = (owner + 1) % 5; held = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] lk);
    @(negedge clk);
    rst_i = r; req_i = rq; lock_i = lk;
    model(r, rq, lk);
    q.push_back('{gnt: owner >= 0 ? 5'(1 << owner) : 5'd0, sel: last_sel, we: owner >= 0,
                  busy: owner >= 0 || turn, rst: r, req: rq, starve_en: starve_en});
  endtask

  task automatic look(input string name, input logic [4:0] g, input int s, input logic w, input logic b);
    checks++;
    if (gnt_o !== g || int'(sel_o) != s || we_en_o !== w || busy_o !== b) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d we=%b busy=%b, expected gnt=%b sel=%0d we=%b busy=%b",
               name, gnt_o, sel_o, we_en_o, busy_o, g, s, w, b);
    end
  endtask

  initial begin
    exp_t e;
    int waitc[5];
    for (int p = 0; p < 5; p++) waitc[p] = 0;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (gnt_o !== e.gnt || int'(sel_o) != e.sel || we_en_o !== e.we || busy_o !== e.busy) begin
          errors++;
          $display("FAIL scoreboard @%0t: got gnt=%b sel=%0d we=%b busy=%b, expected gnt=%b sel=%0d we=%b busy=%b",
                   $time, gnt_o, sel_o, we_en_o, busy_o, e.gnt, e.sel, e.we, e.busy);
        end
        checks++;
        if (!$onehot0(gnt_o) || (we_en_o && (gnt_o == '0 || !busy_o))) begin
          errors++;
          $display("FAIL invariant @%0t: gnt=%b we=%b busy=%b, required one-hot-or-zero grant and we only while granted",
                   $time, gnt_o, we_en_o, busy_o);
        end
        for (int p = 0; p < 5; p++) begin
          if (e.rst || !e.req[p] || gnt_o[p]) waitc[p] = 0;
          else if (!(int'(sel_o) == p && gnt_o == '0)) waitc[p]++;
          if (e.starve_en) begin
            checks++;
            if (waitc[p] > STARVE) begin
              errors++;
              $display("FAIL starvation port %0d @%0t: waited %0d cycles, bound %0d", p, $time, waitc[p], STARVE);
              waitc[p] = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [4:0] rq;
    logic [4:0] lk;
    step(1'b1, 5'b00000, 5'b0);
    step(1'b0, 5'b00100, 5'b0); look("reset", 5'b00000, 0, 1'b0, 1'b0);
    step(1'b0, 5'b00100, 5'b0); look("grant_p2", 5'b00100, 2, 1'b1, 1'b1);
    step(1'b0, 5'b00000, 5'b0); look("hold_p2", 5'b00100, 2, 1'b1, 1'b1);
    step(1'b0, 5'b00000, 5'b0); look("turn_p2", 5'b00000, 2, 1'b0, 1'b1);
    step(1'b0, 5'b00000, 5'b0); look("idle_sel_hold", 5'b00000, 2, 1'b0, 1'b0);
    step(1'b0, 5'b10000, 5'b0);
    step(1'b0, 5'b10000, 5'b0); look("grant_p4", 5'b10000, 4, 1'b1, 1'b1);
    step(1'b1, 5'b10000, 5'b0);
    step(1'b0, 5'b10001, 5'b0); look("reset_mid_grant", 5'b00000, 0, 1'b0, 1'b0);
    step(1'b0, 5'b10001, 5'b0); look("after_reset_p0", 5'b00001, 0, 1'b1, 1'b1);
    step(1'b1, 5'b00000, 5'b0);
    step(1'b0, 5'b11111, 5'b0);
    for (int k = 0; k < 36; k++) begin
      step(1'b0, 5'b11111, 5'b0);
      look($sformatf("rotate_%0d", k), (k % 6 < 5) ? 5'(1 << ((k / 6) % 5)) : 5'd0, (k / 6) % 5, k % 6 < 5, 1'b1);
    end
    step(1'b1, 5'b00000, 5'b0);
    step(1'b0, 5'b00010, 5'b00010);
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 5'b01010, 5'b00010);
      look($sformatf("lock_hold_%0d", j), 5'b00010, 1, 1'b1, 1'b1);
    end
    step(1'b0, 5'b01000, 5'b0); look("lock_last", 5'b00010, 1, 1'b1, 1'b1);
    step(1'b0, 5'b01000, 5'b0); look("lock_turn", 5'b00000, 1, 1'b0, 1'b1);
    step(1'b0, 5'b01000, 5'b0); look("lock_next_p3", 5'b01000, 3, 1'b1, 1'b1);
    step(1'b1, 5'b00000, 5'b0);
    step(1'b0, 5'b00001, 5'b0);
    repeat (4) step(1'b0, 5'b00101, 5'b0);
    step(1'b0, 5'b00100, 5'b0); look("pre_max", 5'b00001, 0, 1'b1, 1'b1);
    step(1'b0, 5'b00100, 5'b0); look("max_release_turn", 5'b00000, 0, 1'b0, 1'b1);
    step(1'b0, 5'b00100, 5'b0); look("max_release_next", 5'b00100, 2, 1'b1, 1'b1);
    step(1'b1, 5'b00000, 5'b0);
    starve_en = 1'b1;
    rq = 5'd0;
    lk = 5'd0;
    for (int c = 0; c < 5000; c++) begin
      for (int p = 0; p < 5; p++) rq[p] = rq[p] ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
      step($urandom_range(499) == 0, rq, 5'd0);
    end
    starve_en = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      for (int p = 0; p < 5; p++) rq[p] = rq[p] ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) lk = 5'($urandom & $urandom);
      step($urandom_range(499) == 0, rq, lk);
    end
    step(1'b1, 5'b00000, 5'b0);
    @(posedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
